// File: rtl/sar_search_ctrl_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_search_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } sar_state_t;

  // Comparator flags are only trustworthy when exactly one is asserted.
  function automatic logic flags_valid(input logic greater, input logic equal,
                                       input logic less);
    return ({1'b0, greater} + {1'b0, equal} + {1'b0, less}) == 2'd1;
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-search controller: drives guess onto a magnitude comparator and
// narrows [lo, hi] until the comparator reports equality or the range empties.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_greater,
  input  logic             cmp_equal,
  input  logic             cmp_less,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] probes
);

  // Bounds carry an extra bit so guess+1 / guess-1 never wrap.
  localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};

  sar_state_t     state, state_n;
  logic [WIDTH:0] lo, lo_n, hi, hi_n;
  logic [WIDTH-1:0] guess_n, result_n;
  logic [CNT_W-1:0] probes_n;
  logic           found_n, error_n;
  logic [WIDTH:0] guess_x;

  function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH:0] l,
                                               input logic [WIDTH:0] h);
    logic [WIDTH:0] m;
    m = l + ((h - l) >> 1);
    return m[WIDTH-1:0];
  endfunction

  assign guess_x = {1'b0, guess};
  assign busy    = (state == PROBE) || (state == EVAL);
  assign done    = (state == DONE);

  // Register all search state; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      result <= '0;
      probes <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      result <= result_n;
      probes <= probes_n;
      found  <= found_n;
      error  <= error_n;
    end
  end

  // Next-state and datapath updates; everything holds unless changed below.
  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    guess_n  = guess;
    result_n = result;
    probes_n = probes;
    found_n  = found;
    error_n  = error;
    case (state)
      IDLE: begin
        if (start) begin
          lo_n     = '0;
          hi_n     = HI_INIT;
          guess_n  = mid_of('0, HI_INIT);
          found_n  = 1'b0;
          error_n  = 1'b0;
          probes_n = '0;
          state_n  = PROBE;
        end
      end
      PROBE: state_n = EVAL;
      EVAL: begin
        probes_n = probes + 1'b1;
        state_n  = DONE;
        if (!flags_valid(cmp_greater, cmp_equal, cmp_less)) begin
          error_n = 1'b1;
        end else if (cmp_equal) begin
          result_n = guess;
          found_n  = 1'b1;
        end else if (cmp_greater) begin
          if (guess_x == lo) begin
            error_n = 1'b1;
          end else begin
            hi_n    = guess_x - 1'b1;
            guess_n = mid_of(lo, guess_x - 1'b1);
            state_n = PROBE;
          end
        end else begin
          if (guess_x == hi) begin
            error_n = 1'b1;
          end else begin
            lo_n    = guess_x + 1'b1;
            guess_n = mid_of(guess_x + 1'b1, hi);
            state_n = PROBE;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Randomised self-checking bench for sar_search_ctrl against a plain
// arithmetic binary-search model and a behavioural 4-bit comparator.
module tb_sar_search_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 2);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             cmp_greater, cmp_equal, cmp_less;
  logic [WIDTH-1:0] guess, result;
  logic             busy, done, found, error;
  logic [CNT_W-1:0] probes;

  int target = 0;
  int cmp_mode = 0;   // 0 normal, 1 greater+less, 2 none, 3 stuck greater

  int n_tests = 0;
  int n_fail  = 0;

  // model outputs
  int exp_g[8];
  int exp_p, exp_res;
  bit exp_found, exp_err;
  // values captured from the DUT for literal pinning
  int cap_g[8];
  int cap_p, cap_res;

  always #5 clk = ~clk;

  // Behavioural comparator: A = guess, B = target, with fault modes.
  always_comb begin
    cmp_greater = (int'(guess) > target);
    cmp_equal   = (int'(guess) == target);
    cmp_less    = (int'(guess) < target);
    case (cmp_mode)
      1: begin cmp_greater = 1'b1; cmp_equal = 1'b0; cmp_less = 1'b1; end
      2: begin cmp_greater = 1'b0; cmp_equal = 1'b0; cmp_less = 1'b0; end
      3: begin cmp_greater = 1'b1; cmp_equal = 1'b0; cmp_less = 1'b0; end
      default: ;
    endcase
  end

  sar_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmp_greater(cmp_greater), .cmp_equal(cmp_equal), .cmp_less(cmp_less),
    .guess(guess), .busy(busy), .done(done), .found(found), .error(error),
    .result(result), .probes(probes)
  );

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (target %0d mode %0d)",
               name, act, req, target, cmp_mode);
    end
  endtask

  // Plain interval search over integers; flags per comparator mode.
  task automatic model(input int t, input int mode);
    int lo, hi, g;
    bit gt, eq, lt;
    lo = 0; hi = 15; exp_p = 0; exp_found = 0; exp_err = 0; exp_res = 0;
    for (int i = 0; i < 8; i++) exp_g[i] = 0;
    while (1) begin
      g = (lo + hi) / 2;
      exp_g[exp_p] = g;
      exp_p++;
      gt = (g > t); eq = (g == t); lt = (g < t);
      if (mode == 1) begin gt = 1; eq = 0; lt = 1; end
      if (mode == 2) begin gt = 0; eq = 0; lt = 0; end
      if (mode == 3) begin gt = 1; eq = 0; lt = 0; end
      if (int'(gt) + int'(eq) + int'(lt) != 1) begin exp_err = 1; break; end
      if (eq) begin exp_found = 1; exp_res = g; break; end
      if (gt) begin
        if (g == lo) begin exp_err = 1; break; end
        hi = g - 1;
      end else begin
        if (g == hi) begin exp_err = 1; break; end
        lo = g + 1;
      end
    end
  endtask

  // One search: called at a negedge with the DUT in IDLE. Every cycle of
  // the search is compared; restart_at pulses start mid-search, and
  // start_on_done raises start during the done cycle (both must be ignored).
  task automatic run_search(input int t, input int mode, input int restart_at,
                            input bit start_on_done);
    target = t; cmp_mode = mode;
    model(t, mode);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2 * exp_p; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("guess", int'(guess), exp_g[k/2]);
      chk("busy", int'(busy), 1);
      chk("done_low", int'(done), 0);
      chk("probes_run", int'(probes), k / 2);
      chk("flags_clear", int'(found) + int'(error), 0);
      if (k % 2 == 1) cap_g[k/2] = int'(guess);
      if (k == restart_at) start = 1'b1;
    end
    @(negedge clk);
    start = start_on_done;
    chk("done", int'(done), 1);
    chk("busy_done", int'(busy), 0);
    chk("found", int'(found), int'(exp_found));
    chk("error", int'(error), int'(exp_err));
    chk("probes", int'(probes), exp_p);
    chk("guess_hold", int'(guess), exp_g[exp_p-1]);
    if (exp_found) chk("result", int'(result), exp_res);
    cap_p = int'(probes); cap_res = int'(result);
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("found_hold", int'(found), int'(exp_found));
    chk("probes_hold", int'(probes), exp_p);
  endtask

  initial begin
    #1;
    chk("rst_guess", int'(guess), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_probes", int'(probes), 0);
    chk("rst_flags", int'(busy) + int'(done) + int'(found) + int'(error), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Hand-computed anchors
    run_search(7, 0, -1, 0);
    chk("t7_probes_lit", cap_p, 1);
    chk("t7_result_lit", cap_res, 7);
    run_search(0, 0, -1, 0);
    chk("t0_probes_lit", cap_p, 4);
    chk("t0_g0_lit", cap_g[0], 7);
    chk("t0_g1_lit", cap_g[1], 3);
    chk("t0_g2_lit", cap_g[2], 1);
    chk("t0_g3_lit", cap_g[3], 0);
    run_search(15, 0, -1, 0);
    chk("t15_probes_lit", cap_p, 5);
    chk("t15_g4_lit", cap_g[4], 15);
    chk("t15_result_lit", cap_res, 15);

    // Full sweep, back to back
    for (int t = 0; t < 16; t++) begin
      run_search(t, 0, -1, 0);
      chk("sweep_result", cap_res, t);
      chk("sweep_pmax", int'(cap_p <= 5), 1);
    end

    // Invalid flag patterns and stuck comparator
    run_search(5, 1, -1, 0);
    chk("both_probes_lit", cap_p, 1);
    run_search(5, 2, -1, 0);
    chk("none_probes_lit", cap_p, 1);
    run_search(5, 3, -1, 0);
    chk("stuck_probes_lit", cap_p, 4);

    // start mid-search and during done must be ignored
    run_search(0, 0, 3, 0);
    run_search(9, 0, 0, 1);
    run_search(12, 0, -1, 0);

    // Randomised targets with random stray start pulses
    for (int i = 0; i < 30; i++)
      run_search(int'($urandom_range(15)), 0, int'($urandom_range(9)) - 1,
                 1'($urandom_range(1)));

    // Reset during the third probe
    target = 0; cmp_mode = 0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_guess", int'(guess), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_guess", int'(guess), 0);
    chk("mid_rst_probes", int'(probes), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_flags", int'(busy) + int'(done) + int'(found) + int'(error), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(done) + int'(busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
